// File: rtl/a23_imm_encoder_pkg.sv
// a23_imm_encoder_pkg
// Shared definitions for the immediate encoder: field widths, rotate step
// count and the search FSM state encoding.
package a23_imm_encoder_pkg;

  localparam int unsigned IMM_W     = 8;
  localparam int unsigned ROT_W     = 4;
  localparam int unsigned ROT_STEPS = 16;

  localparam logic [ROT_W-1:0] LAST_ROT = ROT_W'(ROT_STEPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SEARCH     = 2'd1,
    ST_SEARCH_INV = 2'd2,
    ST_DONE       = 2'd3
  } state_t;

endpackage

// File: rtl/a23_imm_encoder_fit.sv
// a23_imm_fit
// Combinational fit check for one rotate step of the immediate search.
// The working word is ROL(candidate, 2*rot); it fits when only the low
// IMM_W bits are set.
//   work          : working word for the current rotate step
//   rot           : current rotate field
//   hit           : work fits in an 8-bit immediate
//   carry_out     : bit 31 of ROR(work[7:0], 2*rot), valid when rot != 0
//   carry_defined : rot != 0 (rot 0 passes the incoming carry through)
module a23_imm_fit
  import a23_imm_encoder_pkg::*;
(
  input  logic [31:0]      work,
  input  logic [ROT_W-1:0] rot,
  output logic             hit,
  output logic             carry_out,
  output logic             carry_defined
);

  // ROR by 2*rot moves bit (2*rot-1) of the immediate into bit 31.
  // On a hit every bit above IMM_W is zero, so indexing work directly
  // gives the right answer without a shifter.
  logic [ROT_W:0] msb_idx;

  always_comb begin
    msb_idx       = {rot, 1'b0} - (ROT_W + 1)'(1);
    hit           = (work[31:IMM_W] == '0);
    carry_defined = (rot != '0);
    carry_out     = carry_defined & work[msb_idx];
  end

endmodule

// File: rtl/a23_imm_encoder.sv
// a23_imm_encoder
// Multi-cycle search for the ARM data-processing immediate {rot4, imm8}
// with value == ROR(imm8, 2*rot4). One rotate step is tried per cycle,
// lowest rot first; an optional second pass tries ~value.
//   i_clk, i_rst_n   : clock, async active-low reset
//   i_start          : request, accepted in IDLE only
//   i_value          : constant to encode (captured on accept)
//   i_allow_invert   : enable the ~value pass (captured on accept)
//   o_busy, o_done   : busy flag, single-cycle completion pulse
//   o_valid, o_imm8, o_rot4, o_inverted : result fields, held
//   o_carry_out, o_carry_defined        : shifter carry for the result, held
module a23_imm_encoder
  import a23_imm_encoder_pkg::*;
#(
  parameter int unsigned INVERT_EN = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [31:0]      i_value,
  input  logic             i_allow_invert,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_valid,
  output logic [IMM_W-1:0] o_imm8,
  output logic [ROT_W-1:0] o_rot4,
  output logic             o_inverted,
  output logic             o_carry_out,
  output logic             o_carry_defined
);

  state_t           state;
  logic [31:0]      work;
  logic [31:0]      captured;
  logic [ROT_W-1:0] rot;
  logic             inv;
  logic             spent;
  logic             fit_hit;
  logic             fit_cout;
  logic             fit_cdef;

  a23_imm_fit u_fit (
    .work          (work),
    .rot           (rot),
    .hit           (fit_hit),
    .carry_out     (fit_cout),
    .carry_defined (fit_cdef)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= ST_IDLE;
      work            <= '0;
      captured        <= '0;
      rot             <= '0;
      inv             <= 1'b0;
      spent           <= 1'b0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_valid         <= 1'b0;
      o_imm8          <= '0;
      o_rot4          <= '0;
      o_inverted      <= 1'b0;
      o_carry_out     <= 1'b0;
      o_carry_defined <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            work            <= i_value;
            captured        <= i_value;
            inv             <= i_allow_invert && (INVERT_EN != 0);
            rot             <= '0;
            spent           <= 1'b0;
            state           <= ST_SEARCH;
            o_busy          <= 1'b1;
            o_valid         <= 1'b0;
            o_imm8          <= '0;
            o_rot4          <= '0;
            o_inverted      <= 1'b0;
            o_carry_out     <= 1'b0;
            o_carry_defined <= 1'b0;
          end
        end

        ST_SEARCH, ST_SEARCH_INV: begin
          // A fully failed final pass spends one extra cycle here, so a
          // miss completes where a hit at rot 16 would.
          if (spent) begin
            state  <= ST_DONE;
            o_done <= 1'b1;
          end else if (fit_hit) begin
            o_imm8          <= work[IMM_W-1:0];
            o_rot4          <= rot;
            o_valid         <= 1'b1;
            o_inverted      <= (state == ST_SEARCH_INV);
            o_carry_out     <= fit_cout;
            o_carry_defined <= fit_cdef;
            state           <= ST_DONE;
            o_done          <= 1'b1;
          end else if (rot == LAST_ROT) begin
            if (state == ST_SEARCH && inv) begin
              work  <= ~captured;
              rot   <= '0;
              state <= ST_SEARCH_INV;
            end else begin
              spent <= 1'b1;
            end
          end else begin
            work <= {work[29:0], work[31:30]};
            rot  <= rot + 1'b1;
          end
        end

        ST_DONE: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a23_imm_encoder.sv
// tb_a23_imm_encoder
// Self-checking bench for a23_imm_encoder: directed cases, randomized
// constants and a full {imm8, rot4} sweep against a behavioural model.
module tb_a23_imm_encoder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] value;
  logic        allow_invert;
  logic        busy;
  logic        done;
  logic        valid;
  logic [7:0]  imm8;
  logic [3:0]  rot4;
  logic        inverted;
  logic        carry_out;
  logic        carry_defined;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  a23_imm_encoder #(.INVERT_EN(1)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_start         (start),
    .i_value         (value),
    .i_allow_invert  (allow_invert),
    .o_busy          (busy),
    .o_done          (done),
    .o_valid         (valid),
    .o_imm8          (imm8),
    .o_rot4          (rot4),
    .o_inverted      (inverted),
    .o_carry_out     (carry_out),
    .o_carry_defined (carry_defined)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       valid;
    bit [7:0] imm;
    bit [3:0] rot;
    bit       inverted;
    bit       cout;
    bit       cdef;
    int       lat;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] x, input int unsigned n);
    logic [63:0] d;
    d = {x, x} >> (n % 32);
    return d[31:0];
  endfunction

  // Reference: first (pass, rot) for which rotating the target left by
  // 2*rot leaves something below 256; latency follows the step count.
  function automatic exp_t model(input logic [31:0] v, input bit allow);
    exp_t        e;
    logic [31:0] t;
    logic [31:0] cand;
    logic [31:0] dec;
    e.valid = 0; e.imm = 0; e.rot = 0; e.inverted = 0; e.cout = 0; e.cdef = 0;
    e.lat = allow ? 34 : 18;
    for (int p = 0; p < 2; p++) begin
      if (p == 1 && !allow) break;
      t = (p == 1) ? ~v : v;
      for (int unsigned r = 0; r < 16; r++) begin
        cand = ror32(t, (32 - 2 * r) % 32);
        if (cand < 256) begin
          dec        = ror32(cand, 2 * r);
          e.valid    = 1;
          e.imm      = cand[7:0];
          e.rot      = 4'(r);
          e.inverted = (p == 1);
          e.cdef     = (r != 0);
          e.cout     = (r != 0) && dec[31];
          e.lat      = (p == 0) ? int'(r) + 2 : 18 + int'(r);
          return e;
        end
      end
    end
    return e;
  endfunction

  // Starts at the negedge in cycle 1 after acceptance; returns the cycle in
  // which done was seen (or the bound) and whether busy stayed high.
  task automatic wait_done(output int cyc, output bit busy_ok);
    cyc = 1;
    busy_ok = 1;
    while (1) begin
      if (!busy) busy_ok = 0;
      if (done) break;
      if (cyc >= 40) break;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_result(input string tag, input exp_t e, input int cyc, input bit busy_ok);
    check({tag, "_done_seen"}, done, 1'b1);
    check({tag, "_latency"}, cyc, e.lat);
    check({tag, "_busy"}, busy_ok, 1'b1);
    check({tag, "_valid"}, valid, e.valid);
    check({tag, "_imm8"}, imm8, e.imm);
    check({tag, "_rot4"}, rot4, e.rot);
    check({tag, "_inverted"}, inverted, e.inverted);
    check({tag, "_carry_out"}, carry_out, e.cout);
    check({tag, "_carry_def"}, carry_defined, e.cdef);
  endtask

  task automatic run_encode(input string tag, input logic [31:0] v, input bit allow);
    exp_t e;
    int   cyc;
    bit   busy_ok;
    e = model(v, allow);
    @(negedge clk);
    start = 1'b1; value = v; allow_invert = allow;
    @(negedge clk);
    start = 1'b0; value = $urandom; allow_invert = 1'($urandom);
    check({tag, "_cleared"}, {valid, imm8, rot4, inverted, carry_out, carry_defined}, '0);
    wait_done(cyc, busy_ok);
    check_result(tag, e, cyc, busy_ok);
    if (e.valid)
      check({tag, "_decode"}, ror32({24'd0, imm8}, 2 * rot4) ^ {32{inverted}}, v);
    @(negedge clk);
    check({tag, "_pulse"}, {done, busy}, 2'b00);
  endtask

  initial begin
    exp_t        e;
    int          cyc;
    bit          busy_ok;
    bit          saw_done;
    logic [31:0] v;

    rst_n = 1'b0; start = 1'b0; value = '0; allow_invert = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {busy, done, valid, imm8, rot4, inverted, carry_out, carry_defined}, '0);
    rst_n = 1'b1;

    run_encode("ff",        32'h0000_00FF, 1'b0);
    run_encode("ff000000",  32'hFF00_0000, 1'b0);
    run_encode("f000000f",  32'hF000_000F, 1'b0);
    run_encode("inv_hit",   32'hFFFF_FF00, 1'b1);
    run_encode("inv_off",   32'hFFFF_FF00, 1'b0);
    run_encode("two_miss",  32'h0000_0102, 1'b1);
    run_encode("zero",      32'h0000_0000, 1'b1);

    // i_start held high through a search while i_value changes.
    @(negedge clk);
    start = 1'b1; value = 32'hFF00_0000; allow_invert = 1'b0;
    @(negedge clk);
    value = 32'h0000_00FF;
    wait_done(cyc, busy_ok);
    check_result("hold_first", model(32'hFF00_0000, 1'b0), cyc, busy_ok);
    @(negedge clk);
    check("hold_idle_gap", busy, 1'b0);
    @(negedge clk);
    check("hold_reaccept", busy, 1'b1);
    start = 1'b0;
    wait_done(cyc, busy_ok);
    check_result("hold_second", model(32'h0000_00FF, 1'b0), cyc, busy_ok);
    @(negedge clk);

    // Reset in cycle 5 of a long search.
    @(negedge clk);
    start = 1'b1; value = 32'h0000_0102; allow_invert = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("midreset_outputs",
             {busy, done, valid, imm8, rot4, inverted, carry_out, carry_defined}, '0);
    saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (done) saw_done = 1;
    end
    check("midreset_no_done", saw_done, 1'b0);
    e = model(32'h0000_03FC, 1'b0);
    check("rot15_model_lat", e.lat, 17);
    run_encode("rot15", 32'h0000_03FC, 1'b0);

    // Randomized constants: raw words and encodable (optionally complemented) words.
    for (int i = 0; i < 120; i++) begin
      if (i % 2 == 0)
        v = $urandom;
      else
        v = ror32({24'd0, 8'($urandom)}, 2 * $urandom_range(0, 15)) ^ {32{1'($urandom)}};
      run_encode($sformatf("rand%0d", i), v, 1'($urandom));
    end

    // Every {imm8, rot4} pair: decode, encode, compare against the model.
    for (int unsigned im = 0; im < 256; im++) begin
      for (int unsigned r = 0; r < 16; r++) begin
        run_encode($sformatf("sweep_%0h_%0d", im, r), ror32(im, 2 * r), 1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/a23_imm_encoder.md
Name: a23_imm_encoder

Overview:
- Multi-cycle inverse of the a23 immediate/ROR shifter path. Given a 32-bit constant, it searches for the ARM data-processing immediate encoding {rot4, imm8} such that value == ROR(imm8, 2*rot4).
- An optional second pass searches the bitwise complement, for MOV->MVN / CMP->CMN style substitution.
- Used by the assembler-side constant loader and by the shifter verification bench to build immediate operands. One rotate step is checked per cycle, so no barrel shifter is needed.

Parameters:
- INVERT_EN, 1, 1 = the inverted second pass is built; 0 = i_allow_invert is ignored and only one pass runs.

Ports:
- i_clk  input  1  system clock, all state on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_start  input  1  request; sampled only in IDLE
- i_value  input  32  constant to encode; captured on the accepted i_start
- i_allow_invert  input  1  captured with i_start; enables the ~value pass
- o_busy  output  1  high from the cycle after acceptance until o_done
- o_done  output  1  single-cycle completion pulse
- o_valid  output  1  encoding found; held until the next accepted start
- o_imm8  output  8  immediate field; held
- o_rot4  output  4  rotate field (rotate right by 2*o_rot4); held
- o_inverted  output  1  encoding applies to ~i_value; held
- o_carry_out  output  1  shifter carry for this immediate = bit 31 of the decoded value when o_rot4 != 0, else 0; held
- o_carry_defined  output  1  1 when o_rot4 != 0; 0 means the shifter passes carry_in through; held

Behaviour:
- Reset (async assert, sync release): state=IDLE; every output=0; working register=0; rot counter=0.
- States: IDLE, SEARCH, SEARCH_INV, DONE.
- IDLE: on i_start, capture work=i_value, inv=i_allow_invert&INVERT_EN, rot=0, go to SEARCH. Clear o_valid, o_imm8, o_rot4, o_inverted, o_carry_out, o_carry_defined.
- SEARCH/SEARCH_INV, each cycle, check the current rot:
  - Hit when work[31:8]==0 (work always equals ROL(candidate, 2*rot)).
  - On hit: load o_imm8=work[7:0], o_rot4=rot, o_valid=1, o_inverted=(state==SEARCH_INV), carry fields; go to DONE.
  - On miss: work=ROL(work,2), rot=rot+1 (4-bit).
  - Miss at rot==15 in SEARCH: if inv, work=~captured value, rot=0, go to SEARCH_INV; else go to DONE with o_valid=0.
  - Miss at rot==15 in SEARCH_INV: go to DONE with o_valid=0.
- DONE: o_done=1 for exactly this cycle; next cycle IDLE. A new i_start is accepted from IDLE only, so the back-to-back minimum is 1 idle cycle.
- Latency, counting the accept edge as cycle 0:
  - Hit at rot r in pass 1: o_done in cycle r+2.
  - Hit at rot r in pass 2: o_done in cycle 18+r.
  - No hit: o_done in cycle 18 (one pass) or 34 (two passes).
- Search order is pass 1 before pass 2, and lowest rot first within a pass. The smallest rot therefore always wins, and a non-inverted hit always beats an inverted one.
- o_busy = state in {SEARCH, SEARCH_INV, DONE}.
- i_start while not IDLE: ignored, with no queuing. i_value/i_allow_invert changes after capture: no effect.
- Value 0: hit at rot 0, imm8=0, carry undefined (o_carry_defined=0).
- Reset mid-search: immediate return to IDLE; outputs cleared; no o_done pulse.

Decomposition:
- Shared package/include: state encodings (2-bit), IMM_W=8, ROT_W=4, ROT_STEPS=16 in the a23 localparams include.
- One natural sub-module, a23_imm_fit: combinational check of work[31:8]==0 plus carry derivation. Everything else stays in the top FSM.

Test Plan:
- i_value=0x000000FF, invert off -> o_done at cycle 2; valid=1, imm8=0xFF, rot4=0, inverted=0, carry_defined=0.
- i_value=0xFF000000 -> done at cycle 6; imm8=0xFF, rot4=4, carry_out=1, carry_defined=1. Also i_value=0xF000000F -> imm8=0xFF, rot4=2, done at cycle 4.
- i_value=0xFFFFFF00, allow_invert=1 -> done at cycle 18; imm8=0xFF, rot4=0, inverted=1. Same value with allow_invert=0 -> done at cycle 18, valid=0.
- i_value=0x00000102, allow_invert=1 -> done at cycle 34, valid=0. Confirm o_busy is high for cycles 1..34 and o_done is a 1-cycle pulse.
- Hold i_start high through a search with a different i_value -> the result matches the first value only. The next accept is in the cycle after DONE.
- Assert i_rst_n=0 at cycle 5 of a 0x00000102 search -> all outputs 0 immediately, no o_done. A later start of 0x3FC (imm8=0xFF, rot4=15) completes at cycle 17.
- Exhaustive sweep: for all 4096 {imm8, rot4} pairs, decode through the a23 barrel shifter ROR, then encode -> the decoded value of the result matches, and the rot is minimal.
